midi_parser_mc: RTL and testbench

Parametrised multi-channel MIDI parser with a buffered message output, the successor to the single-channel parser. It sits between the MIDI UART receiver and the voice allocator / CC router in the audio clock domain. It assembles channel-voice and system-common messages using running status, and filters channel messages against a 16-bit channel mask. Completed messages are queued in a first-word-fall-through FIFO with valid/ready backpressure. Real-time bytes bypass the FIFO.

---
 rtl/midi_parser_mc.sv | 241 ++++++++++++++++++++++++
 tb/tb_midi_parser_mc.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_parser_mc.sv
// Multi-channel MIDI byte-stream parser with running status, channel masking,
// SysEx draining and a first-word-fall-through message FIFO.
// Real-time bytes (F8-FF) bypass the FIFO as a one-cycle pulse.
module midi_parser_mc #(
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = 8,
    parameter bit VEL0_TO_NOTEOFF = 1'b1
) (
    input  logic                          i_clk_aud,
    input  logic                          i_aud_rst,
    input  logic                          i_byte_valid,
    input  logic [7:0]                    i_midi_byte,
    input  logic [15:0]                   i_chan_mask,
    output logic                          o_msg_valid,
    input  logic                          i_msg_ready,
    output logic [1:0]                    o_msg_len,
    output logic [7:0]                    o_msg [3],
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [CNT_W-1:0]              o_drop_count,
    output logic                          o_rt_valid,
    output logic [7:0]                    o_rt_msg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [1:0] len;
        logic [7:0] b2;
        logic [7:0] b1;
        logic [7:0] b0;
    } msg_t;

    localparam msg_t MSG_ZERO = '{len: 2'd0, b2: 8'h00, b1: 8'h00, b0: 8'h00};

    // Parser mode: no running status, running status held, or draining SysEx
    typedef enum logic [1:0] {
        M_NORS  = 2'd0,
        M_RS    = 2'd1,
        M_SYSEX = 2'd2
    } mode_e;

    mode_e       mode_q, mode_d;
    logic [7:0]  rs_q, rs_d;
    logic        idx_q, idx_d;
    logic [7:0]  d1_q, d1_d;
    logic        rt_valid_q, rt_valid_d;
    logic [7:0]  rt_msg_q, rt_msg_d;
    logic        s1_valid_q, s1_valid_d;
    msg_t        s1_msg_q, s1_msg_d;
    msg_t        asm_s;
    logic        need_two_s;

    msg_t        mem_q [FIFO_DEPTH];
    msg_t        mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic        pop_s, push_s, drop_s, full_s;
    msg_t        head_s;

    // Running status types that carry two data bytes (everything but Cn, Dn, F1, F3)
    assign need_two_s = !((rs_q[7:4] == 4'hC) || (rs_q[7:4] == 4'hD) ||
                          (rs_q == 8'hF1) || (rs_q == 8'hF3));

    // Byte classification, message assembly and stage-1 message capture
    always_comb begin
        mode_d     = mode_q;
        rs_d       = rs_q;
        idx_d      = idx_q;
        d1_d       = d1_q;
        rt_valid_d = 1'b0;
        rt_msg_d   = rt_msg_q;
        s1_valid_d = 1'b0;
        s1_msg_d   = s1_msg_q;

        asm_s = MSG_ZERO;
        if (need_two_s) begin
            asm_s.len = 2'd3;
            asm_s.b1  = d1_q;
            asm_s.b2  = i_midi_byte;
        end else begin
            asm_s.len = 2'd2;
            asm_s.b1  = i_midi_byte;
            asm_s.b2  = 8'h00;
        end
        // Note On with zero velocity is reported as the equivalent Note Off
        if (VEL0_TO_NOTEOFF && (rs_q[7:4] == 4'h9) && (i_midi_byte == 8'h00)) begin
            asm_s.b0 = {4'h8, rs_q[3:0]};
        end else begin
            asm_s.b0 = rs_q;
        end

        if (i_byte_valid) begin
            if (i_midi_byte >= 8'hF8) begin
                // Real-time: pulse only, parser state untouched
                rt_valid_d = 1'b1;
                rt_msg_d   = i_midi_byte;
            end else if (!i_midi_byte[7]) begin
                if (mode_q == M_RS) begin
                    if (need_two_s && !idx_q) begin
                        d1_d  = i_midi_byte;
                        idx_d = 1'b1;
                    end else begin
                        idx_d    = 1'b0;
                        s1_msg_d = asm_s;
                        if (rs_q[7:4] == 4'hF) begin
                            // System common completes and drops running status
                            s1_valid_d = 1'b1;
                            mode_d     = M_NORS;
                        end else begin
                            s1_valid_d = i_chan_mask[rs_q[3:0]];
                        end
                    end
                end else begin
                    // No running status or inside SysEx: data discarded
                    idx_d = idx_q;
                end
            end else begin
                case (i_midi_byte)
                    8'hF0: begin
                        mode_d = M_SYSEX;
                        idx_d  = 1'b0;
                    end
                    8'hF7: begin
                        // Only meaningful as SysEx end; otherwise ignored
                        if (mode_q == M_SYSEX) begin
                            mode_d = M_NORS;
                        end else begin
                            mode_d = mode_q;
                        end
                    end
                    8'hF4, 8'hF5: begin
                        mode_d = M_NORS;
                        idx_d  = 1'b0;
                    end
                    8'hF6: begin
                        mode_d     = M_NORS;
                        idx_d      = 1'b0;
                        s1_valid_d = 1'b1;
                        s1_msg_d   = '{len: 2'd1, b2: 8'h00, b1: 8'h00, b0: 8'hF6};
                    end
                    default: begin
                        // Channel status or F1/F2/F3: start a new message
                        mode_d = M_RS;
                        rs_d   = i_midi_byte;
                        idx_d  = 1'b0;
                    end
                endcase
            end
        end else begin
            mode_d = mode_q;
        end
    end

    // Parser and stage-1 registers
    always_ff @(posedge i_clk_aud or posedge i_aud_rst) begin
        if (i_aud_rst) begin
            mode_q     <= M_NORS;
            rs_q       <= 8'h00;
            idx_q      <= 1'b0;
            d1_q       <= 8'h00;
            rt_valid_q <= 1'b0;
            rt_msg_q   <= 8'h00;
            s1_valid_q <= 1'b0;
            s1_msg_q   <= MSG_ZERO;
        end else begin
            mode_q     <= mode_d;
            rs_q       <= rs_d;
            idx_q      <= idx_d;
            d1_q       <= d1_d;
            rt_valid_q <= rt_valid_d;
            rt_msg_q   <= rt_msg_d;
            s1_valid_q <= s1_valid_d;
            s1_msg_q   <= s1_msg_d;
        end
    end

    assign full_s = (level_q == LW'(FIFO_DEPTH));
    assign pop_s  = o_msg_valid && i_msg_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign push_s = s1_valid_q && (!full_s || pop_s);
    assign drop_s = s1_valid_q && full_s && !pop_s;

    // FIFO write/read pointer, level and saturating drop counter next-state
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = s1_msg_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (drop_s && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end else begin
            drop_d = drop_q;
        end
    end

    // FIFO storage and bookkeeping registers
    always_ff @(posedge i_clk_aud or posedge i_aud_rst) begin
        if (i_aud_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= MSG_ZERO;
            end
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            level_q  <= LW'(0);
            drop_q   <= CNT_W'(0);
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    assign head_s       = mem_q[rd_ptr_q];
    assign o_msg_valid  = (level_q != LW'(0));
    assign o_msg_len    = o_msg_valid ? head_s.len : 2'd0;
    assign o_msg[0]     = o_msg_valid ? head_s.b0 : 8'h00;
    assign o_msg[1]     = o_msg_valid ? head_s.b1 : 8'h00;
    assign o_msg[2]     = o_msg_valid ? head_s.b2 : 8'h00;
    assign o_fifo_level = level_q;
    assign o_drop_count = drop_q;
    assign o_rt_valid   = rt_valid_q;
    assign o_rt_msg     = rt_msg_q;

endmodule

// File: tb/tb_midi_parser_mc.sv
// Self-checking bench for midi_parser_mc: a queue-based behavioural model is
// compared against the DUT every cycle, plus hand-computed directed checks.
module tb_midi_parser_mc;

    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int DMAX  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_byte_valid;
    logic [7:0]  i_midi_byte;
    logic [15:0] i_chan_mask;
    logic        o_msg_valid;
    logic        i_msg_ready;
    logic [1:0]  o_msg_len;
    logic [7:0]  o_msg [3];
    logic [2:0]  o_fifo_level;
    logic [CW-1:0] o_drop_count;
    logic        o_rt_valid;
    logic [7:0]  o_rt_msg;

    midi_parser_mc #(.FIFO_DEPTH(DEPTH), .CNT_W(CW), .VEL0_TO_NOTEOFF(1'b1)) dut (
        .i_clk_aud   (clk),
        .i_aud_rst   (rst),
        .i_byte_valid(i_byte_valid),
        .i_midi_byte (i_midi_byte),
        .i_chan_mask (i_chan_mask),
        .o_msg_valid (o_msg_valid),
        .i_msg_ready (i_msg_ready),
        .o_msg_len   (o_msg_len),
        .o_msg       (o_msg),
        .o_fifo_level(o_fifo_level),
        .o_drop_count(o_drop_count),
        .o_rt_valid  (o_rt_valid),
        .o_rt_msg    (o_rt_msg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] len;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } tmsg_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    tmsg_t      m_fifo[$];
    tmsg_t      dut_log[$];
    logic [7:0] m_data[$];
    int         m_rs = -1;
    bit         m_sysex = 1'b0;
    bit         m_pend_v = 1'b0;
    tmsg_t      m_pend = '0;
    int         m_drop = 0;
    bit         m_rt_v = 1'b0;
    logic [7:0] m_rt = 8'h00;

    function automatic int msg_len(input logic [7:0] s);
        if (s[7:4] == 4'hC || s[7:4] == 4'hD || s == 8'hF1 || s == 8'hF3) return 2;
        if (s == 8'hF6) return 1;
        return 3;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit pop;
        bit nv;
        tmsg_t nm;
        logic [7:0] b;
        int len;
        if (rst) begin
            m_fifo.delete();
            m_data.delete();
            m_rs = -1; m_sysex = 0; m_pend_v = 0; m_pend = '0;
            m_drop = 0; m_rt_v = 0; m_rt = 8'h00;
        end else begin
            pop = (m_fifo.size() > 0) && i_msg_ready;
            if (pop) void'(m_fifo.pop_front());
            if (m_pend_v) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pend);
                else if (m_drop < DMAX) m_drop++;
            end
            nv = 0; nm = '0; m_rt_v = 0;
            if (i_byte_valid) begin
                b = i_midi_byte;
                if (b >= 8'hF8) begin
                    m_rt_v = 1; m_rt = b;
                end else if (b < 8'h80) begin
                    if (!m_sysex && m_rs >= 0) begin
                        m_data.push_back(b);
                        len = msg_len(m_rs[7:0]);
                        if (m_data.size() + 1 == len) begin
                            nm.len = len[1:0];
                            nm.b0  = m_rs[7:0];
                            nm.b1  = m_data[0];
                            nm.b2  = (len == 3) ? m_data[1] : 8'h00;
                            if (nm.b0[7:4] == 4'h9 && len == 3 && nm.b2 == 8'h00) nm.b0[7:4] = 4'h8;
                            m_data.delete();
                            if (m_rs >= 240) begin
                                nv = 1; m_rs = -1;
                            end else begin
                                nv = i_chan_mask[m_rs & 15];
                            end
                        end
                    end
                end else begin
                    case (b)
                        8'hF0: begin m_sysex = 1; m_rs = -1; m_data.delete(); end
                        8'hF7: begin if (m_sysex) m_sysex = 0; end
                        8'hF4, 8'hF5: begin m_sysex = 0; m_rs = -1; m_data.delete(); end
                        8'hF6: begin
                            m_sysex = 0; m_rs = -1; m_data.delete();
                            nv = 1; nm.len = 2'd1; nm.b0 = 8'hF6; nm.b1 = 8'h00; nm.b2 = 8'h00;
                        end
                        default: begin m_sysex = 0; m_rs = b; m_data.delete(); end
                    endcase
                end
            end
            m_pend_v = nv;
            m_pend   = nm;
        end
    end

    // Per-cycle comparison of every output against the model, plus pop logging
    always @(negedge clk) begin
        chk("msg_valid", {31'd0, o_msg_valid}, {31'd0, m_fifo.size() > 0});
        if (m_fifo.size() > 0)
            chk("head", {6'd0, o_msg_len, o_msg[0], o_msg[1], o_msg[2]}, {6'd0, m_fifo[0]});
        chk("level", {29'd0, o_fifo_level}, m_fifo.size());
        chk("drop", {30'd0, o_drop_count}, m_drop);
        chk("rt_valid", {31'd0, o_rt_valid}, {31'd0, m_rt_v});
        chk("rt_msg", {24'd0, o_rt_msg}, {24'd0, m_rt});
        if (o_msg_valid && i_msg_ready)
            dut_log.push_back({o_msg_len, o_msg[0], o_msg[1], o_msg[2]});
    end

    // ---------------- stimulus helpers ----------------
    task automatic put_r(input logic v, input logic [7:0] b, input logic r);
        @(posedge clk);
        #1;
        i_byte_valid = v;
        i_midi_byte  = b;
        i_msg_ready  = r;
    endtask

    task automatic put(input logic v, input logic [7:0] b);
        put_r(v, b, i_msg_ready);
    endtask

    task automatic send(input logic [7:0] b);
        put(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 8'h00);
    endtask

    task automatic exp_log(input string name, input int idx, input logic [1:0] len,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [31:0] act;
        act = (idx < dut_log.size()) ? {6'd0, dut_log[idx]} : 32'hFFFF_FFFF;
        chk(name, act, {6'd0, len, b0, b1, b2});
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {o_msg_valid, o_msg_len, o_msg[0], o_msg[1], o_msg[2], o_fifo_level,
                   o_drop_count, o_rt_valid, o_rt_msg}, 32'd0);
        chk({name, "_hi"}, {27'd0, o_msg_valid, o_msg_len, o_rt_valid, o_fifo_level == 3'd0}, 32'd1);
    endtask

    initial begin
        i_byte_valid = 1'b0;
        i_midi_byte  = 8'h00;
        i_chan_mask  = 16'hFFFF;
        i_msg_ready  = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Running status with velocity-0 conversion and 2-cycle latency
        send(8'h90); send(8'h3C); send(8'h64);
        @(negedge clk); chk("lat_k0", {31'd0, o_msg_valid}, 32'd0);
        send(8'h3C);
        @(negedge clk); chk("lat_k1", {31'd0, o_msg_valid}, 32'd0);
        send(8'h00);
        @(negedge clk); chk("lat_k2", {31'd0, o_msg_valid}, 32'd1);
        idle(3);
        chk("t1_level", {29'd0, o_fifo_level}, 32'd2);
        dut_log.delete();
        i_msg_ready = 1'b1; idle(3); i_msg_ready = 1'b0;
        chk("t1_count", dut_log.size(), 32'd2);
        exp_log("t1_m0", 0, 2'd3, 8'h90, 8'h3C, 8'h64);
        exp_log("t1_m1", 1, 2'd3, 8'h80, 8'h3C, 8'h00);

        // Channel mask filtering and 2-byte running status
        i_chan_mask = 16'h0002; i_msg_ready = 1'b1; dut_log.delete();
        send(8'h90); send(8'h40); send(8'h7F);
        send(8'h91); send(8'h40); send(8'h7F);
        send(8'hC1); send(8'h05); send(8'h06);
        idle(4);
        chk("t2_count", dut_log.size(), 32'd3);
        exp_log("t2_m0", 0, 2'd3, 8'h91, 8'h40, 8'h7F);
        exp_log("t2_m1", 1, 2'd2, 8'hC1, 8'h05, 8'h00);
        exp_log("t2_m2", 2, 2'd2, 8'hC1, 8'h06, 8'h00);

        // SysEx drain with an embedded real-time byte
        i_chan_mask = 16'hFFFF; dut_log.delete();
        send(8'hF0); send(8'h01); send(8'h02); send(8'hF8);
        @(negedge clk); chk("rt_k0", {31'd0, o_rt_valid}, 32'd0);
        send(8'h03);
        @(negedge clk); chk("rt_k1", {23'd0, o_rt_valid, o_rt_msg}, 32'h1F8);
        send(8'hF7); send(8'hB0); send(8'h07); send(8'h64);
        idle(4);
        chk("t3_rt_hold", {23'd0, o_rt_valid, o_rt_msg}, 32'h0F8);
        chk("t3_count", dut_log.size(), 32'd1);
        exp_log("t3_m0", 0, 2'd3, 8'hB0, 8'h07, 8'h64);

        // Status terminates SysEx; system common F2; orphan data discarded
        dut_log.delete();
        send(8'hF0); send(8'h01); send(8'h92); send(8'h30); send(8'h40);
        send(8'hF2); send(8'h10); send(8'h20); send(8'h10);
        idle(4);
        chk("t4_count", dut_log.size(), 32'd2);
        exp_log("t4_m0", 0, 2'd3, 8'h92, 8'h30, 8'h40);
        exp_log("t4_m1", 1, 2'd3, 8'hF2, 8'h10, 8'h20);

        // FIFO overflow: six messages into four entries
        i_msg_ready = 1'b0; dut_log.delete();
        for (int i = 1; i <= 6; i++) begin send(8'hC0); send(8'(i)); end
        idle(3);
        chk("t5_level", {29'd0, o_fifo_level}, 32'd4);
        chk("t5_drop", {30'd0, o_drop_count}, 32'd2);
        i_msg_ready = 1'b1; idle(4); i_msg_ready = 1'b0;
        chk("t5_count", dut_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) exp_log("t5_order", i, 2'd2, 8'hC0, 8'(i + 1), 8'h00);
        chk("t5_empty", {29'd0, o_fifo_level}, 32'd0);

        // Write and pop in the same cycle while full: no drop
        dut_log.delete();
        for (int i = 11; i <= 14; i++) begin send(8'hC0); send(8'(i)); end
        idle(3);
        chk("t5b_full", {29'd0, o_fifo_level}, 32'd4);
        send(8'hC0); send(8'h0F);
        put_r(1'b0, 8'h00, 1'b1);
        put_r(1'b0, 8'h00, 1'b0);
        idle(2);
        chk("t5b_level", {29'd0, o_fifo_level}, 32'd4);
        chk("t5b_drop", {30'd0, o_drop_count}, 32'd2);
        i_msg_ready = 1'b1; idle(5); i_msg_ready = 1'b0;
        chk("t5b_count", dut_log.size(), 32'd5);
        exp_log("t5b_first", 0, 2'd2, 8'hC0, 8'h0B, 8'h00);
        exp_log("t5b_last", 4, 2'd2, 8'hC0, 8'h0F, 8'h00);

        // Drop counter saturation with a 2-bit counter
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 9; i++) begin send(8'hC0); send(8'(8'h20 + i)); end
        idle(3);
        chk("t6_sat", {30'd0, o_drop_count}, 32'd3);
        chk("t6_level", {29'd0, o_fifo_level}, 32'd4);

        // Reset mid-message clears everything; next data byte is orphaned
        send(8'h93); send(8'h30);
        @(posedge clk); #1; rst = 1'b1; i_byte_valid = 1'b0;
        @(negedge clk); check_all_zero("t6_rst");
        @(posedge clk); #1 rst = 1'b0;
        send(8'h40);
        idle(4);
        chk("t6_orphan", {28'd0, o_msg_valid, o_fifo_level}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
